// File: rtl/project_select_ctrl.sv
// Wishbone-programmable selector for per-project enables; at most one enable is ever high and
// every change passes through an all-off guard interval (break-before-make).
module project_select_ctrl #(
    parameter int          NUM_PROJECTS = 8,
    parameter int          GUARD_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [NUM_PROJECTS-1:0] active_o,
    output logic                    busy_o
);

    // state  | meaning
    // IDLE   | enables reflect CUR; waiting for REQ to differ from CUR
    // DRAIN  | all enables off, guard counter running down
    // APPLY  | last guard cycle; REQ is copied to CUR at the closing edge
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [7:0]              req_idx, req_idx_nxt;
    logic                    req_en, req_en_nxt;
    logic [7:0]              cur_idx, cur_idx_nxt;
    logic                    cur_en, cur_en_nxt;
    logic [7:0]              cnt, cnt_nxt;
    logic [7:0]              switch_cnt, switch_cnt_nxt;
    logic                    err;
    logic [NUM_PROJECTS-1:0] active_nxt;
    logic                    busy_nxt;

    logic        addr_match, wb_hit;
    logic        ctrl_wr, stat_wr, bad_req_wr;
    logic        eff_en, mismatch;
    logic [31:0] rdata;

    logic unused_inputs;
    assign unused_inputs = ^{wbs_dat_i[31:11], wbs_dat_i[9], wbs_sel_i[3:2], wbs_adr_i[1:0]};

    assign addr_match = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wb_hit     = wbs_cyc_i & wbs_stb_i & addr_match & ~wbs_ack_o;
    assign ctrl_wr    = wb_hit & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
    assign stat_wr    = wb_hit & wbs_we_i & (wbs_adr_i[3:2] == 2'd1);

    assign req_idx_nxt = (ctrl_wr & wbs_sel_i[0]) ? wbs_dat_i[7:0] : req_idx;
    assign req_en_nxt  = (ctrl_wr & wbs_sel_i[1]) ? wbs_dat_i[8]   : req_en;
    assign bad_req_wr  = ctrl_wr & req_en_nxt & (int'(req_idx_nxt) >= NUM_PROJECTS);

    // Out-of-range requests stay stored verbatim but act as a disable.
    assign eff_en   = req_en & (int'(req_idx) < NUM_PROJECTS);
    assign mismatch = (eff_en != cur_en) | (eff_en & (req_idx != cur_idx));

    always_comb begin
        rdata = 32'd0;
        case (wbs_adr_i[3:2])
            2'd0:    rdata = {23'd0, req_en, req_idx};
            2'd1:    rdata = {8'd0, switch_cnt, 5'd0, err, busy_o, cur_en, cur_idx};
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            req_idx   <= 8'd0;
            req_en    <= 1'b0;
            err       <= 1'b0;
        end else begin
            wbs_ack_o <= wb_hit;
            wbs_dat_o <= (wb_hit & ~wbs_we_i) ? rdata : 32'd0;
            req_idx   <= req_idx_nxt;
            req_en    <= req_en_nxt;
            if (bad_req_wr)
                err <= 1'b1;
            else if (stat_wr & wbs_sel_i[1] & wbs_dat_i[10])
                err <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            cur_idx    <= 8'd0;
            cur_en     <= 1'b0;
            switch_cnt <= 8'd0;
            active_o   <= '0;
            busy_o     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            cur_idx    <= cur_idx_nxt;
            cur_en     <= cur_en_nxt;
            switch_cnt <= switch_cnt_nxt;
            active_o   <= active_nxt;
            busy_o     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (mismatch)
                    state_nxt = (GUARD_CYCLES == 1) ? S_APPLY : S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt == 8'd1)
                    state_nxt = S_APPLY;
            end
            S_APPLY: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The guard counter holds the number of off-cycles still to run after the current one.
    always_comb begin
        cnt_nxt        = cnt;
        cur_idx_nxt    = cur_idx;
        cur_en_nxt     = cur_en;
        switch_cnt_nxt = switch_cnt;
        active_nxt     = active_o;
        busy_nxt       = busy_o;
        case (state)
            S_IDLE: begin
                if (mismatch) begin
                    active_nxt = '0;
                    busy_nxt   = 1'b1;
                    cnt_nxt    = 8'(GUARD_CYCLES - 1);
                end
            end
            S_DRAIN: begin
                cnt_nxt = cnt - 8'd1;
            end
            S_APPLY: begin
                cur_idx_nxt    = req_idx;
                cur_en_nxt     = eff_en;
                switch_cnt_nxt = switch_cnt + 8'd1;
                busy_nxt       = 1'b0;
                for (int i = 0; i < NUM_PROJECTS; i++)
                    active_nxt[i] = eff_en & (req_idx == 8'(i));
            end
            default: begin
                active_nxt = '0;
                busy_nxt   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_project_select_ctrl.sv
// Randomised scoreboard bench for project_select_ctrl: a deadline-based reference model predicts
// enables, busy, ack and read data; a negedge monitor compares them against the DUT.
module tb_project_select_ctrl;

    localparam int          NP   = 8;
    localparam int          G    = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, dat = 32'h0;
    logic        ack;
    logic [31:0] dat_o;
    logic [NP-1:0] active;
    logic        busy;

    project_select_ctrl #(.NUM_PROJECTS(NP), .GUARD_CYCLES(G), .BASE_ADDR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .active_o (active),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a switch is a pending deadline, not a state machine.
    int          cyc_n = 0;
    logic [7:0]  m_req_idx = 0, m_cur_idx = 0, m_sw = 0;
    logic        m_req_en = 0, m_cur_en = 0, m_err = 0, m_ack = 0, m_switching = 0;
    int          m_apply_at = 0;
    logic [31:0] exp_q[$];

    always @(posedge clk) begin
        logic        hit, want;
        logic [31:0] rd;
        logic [7:0]  nidx;
        logic        nen;
        if (rst) begin
            m_req_idx = 0; m_req_en = 0; m_cur_idx = 0; m_cur_en = 0;
            m_sw = 0; m_err = 0; m_ack = 0; m_switching = 0;
            exp_q.delete();
        end else begin
            hit = cyc && stb && (adr[31:4] == BASE[31:4]) && !m_ack;
            rd = 32'd0;
            if (hit && !we) begin
                if (adr[3:2] == 2'd0)
                    rd = {23'd0, m_req_en, m_req_idx};
                else if (adr[3:2] == 2'd1)
                    rd = {8'd0, m_sw, 5'd0, m_err, m_switching, m_cur_en, m_cur_idx};
            end
            if (hit) exp_q.push_back(rd);
            m_ack = hit;

            want = m_req_en && (m_req_idx < NP);
            if (m_switching) begin
                if (cyc_n == m_apply_at) begin
                    m_cur_en = want;
                    m_cur_idx = m_req_idx;
                    m_sw = m_sw + 8'd1;
                    m_switching = 0;
                end
            end else if (want != m_cur_en || (want && m_req_idx != m_cur_idx)) begin
                m_switching = 1;
                m_apply_at = cyc_n + G;
            end

            if (hit && we && adr[3:2] == 2'd0) begin
                nidx = sel[0] ? dat[7:0] : m_req_idx;
                nen  = sel[1] ? dat[8] : m_req_en;
                m_req_idx = nidx;
                m_req_en = nen;
                if (nen && nidx >= NP) m_err = 1;
            end else if (hit && we && adr[3:2] == 2'd1 && sel[1] && dat[10]) begin
                m_err = 0;
            end
        end
        cyc_n++;
    end

    logic        mon_en = 1'b0;
    logic [31:0] last_rd = 32'd0;

    always @(negedge clk) begin
        logic [NP-1:0] exp_act;
        if (mon_en) begin
            exp_act = '0;
            if (!m_switching && m_cur_en) exp_act[m_cur_idx[2:0]] = 1'b1;
            check("active", 32'(active), 32'(exp_act));
            check("busy", 32'(busy), 32'(m_switching));
            check("ack", 32'(ack), 32'(m_ack));
            check("onehot", 32'($countones(active) <= 1), 32'd1);
            if (ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    check("rdata", dat_o, exp_q.pop_front());
                    last_rd = dat_o;
                end
            end else begin
                check("rdata_idle", dat_o, 32'd0);
            end
        end
    end

    task automatic wb_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
        @(posedge clk);
        #1;
        cyc = 0; stb = 0; we = 0; sel = 4'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (busy !== 1'b0) check("idle_timeout", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [4:0] bsy_seq, act5_ok;
    logic [3:0] ack_pat;
    int         ack_seen;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        mon_en = 1;

        // Reset state and a STATUS read
        check("reset_active", 32'(active), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        wb_acc(0, BASE + 4, 0, 4'hF);
        @(posedge clk); #1;
        check("status_reset", last_rd, 32'h0);

        // Select project 5, check guard timing
        wb_acc(1, BASE, 32'h105, 4'h3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bsy_seq[k] = busy;
            act5_ok[k] = (active == 8'h20);
        end
        check("busy_window", 32'(bsy_seq), 32'b01111);
        check("enable_at_E5", 32'(act5_ok), 32'b10000);
        wait_idle();
        wb_acc(0, BASE + 4, 0, 4'hF);
        @(posedge clk); #1;
        check("status_idx5", last_rd, 32'h0001_0105);

        // Re-request during drain
        wb_acc(1, BASE, 32'h102, 4'h3);
        wb_acc(1, BASE, 32'h105, 4'h3);
        wait_idle();
        check("back_to_5", 32'(active), 32'h20);
        wb_acc(0, BASE + 4, 0, 4'hF);
        @(posedge clk); #1;
        check("status_cnt2", last_rd, 32'h0002_0105);

        // Out-of-range request, then W1C of err
        wb_acc(1, BASE, 32'h109, 4'h3);
        wait_idle();
        check("bad_idx_off", 32'(active), 32'h0);
        wb_acc(0, BASE + 4, 0, 4'hF);
        @(posedge clk); #1;
        check("status_err", last_rd, 32'h0003_0409);
        wb_acc(0, BASE, 0, 4'hF);
        @(posedge clk); #1;
        check("ctrl_raw", last_rd, 32'h109);
        wb_acc(1, BASE + 4, 32'h400, 4'b0010);
        wb_acc(0, BASE + 4, 0, 4'hF);
        @(posedge clk); #1;
        check("status_err_clr", last_rd, 32'h0003_0009);

        // Reset during drain
        wb_acc(1, BASE, 32'h103, 4'h3);
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        repeat (10) @(posedge clk);
        #1;
        check("no_enable_after_rst", 32'(active), 32'h0);
        wb_acc(0, BASE, 0, 4'hF);
        @(posedge clk); #1;
        check("ctrl_after_rst", last_rd, 32'h0);

        // Foreign address, then held strobe
        ack_seen = 0;
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = BASE + 32'h10; sel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack) ack_seen++;
        end
        check("no_ack_foreign", 32'(ack_seen), 32'd0);
        adr = BASE + 4;
        for (int k = 3; k >= 0; k--) begin
            @(negedge clk);
            ack_pat[k] = ack;
        end
        check("ack_pattern", 32'(ack_pat), 32'b1010);
        cyc = 0; stb = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 6)
                wb_acc(1, BASE, {23'd0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 9))},
                       4'($urandom_range(0, 15)));
            else if (op == 6)
                wb_acc(0, BASE + 32'(4 * $urandom_range(0, 3)), 0, 4'hF);
            else if (op == 7)
                wb_acc(1, BASE + 4, 32'($urandom) & 32'h400, 4'($urandom_range(0, 15)));
            else if (op == 8)
                wb_acc($urandom_range(0, 1) == 1, BASE + 32'h20, 32'h105, 4'hF);
            else
                wb_acc(1, BASE + 32'h8, 32'h1FF, 4'hF);
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
        end
        wait_idle();

        mon_en = 0;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
